// File: rtl/seq_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of DIGIT-wide slices in a WIDTH-bit operand.
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Slice counter width; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_sub_if.sv
// Request/result bundle between a client and the serial subtractor.
interface seq_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero
    );
endinterface

// File: rtl/seq_sub_digit.sv
// DIGIT-bit combinational subtract slice: {bo, d} = x - y - bi.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);
    logic [DIGIT:0] br;

    assign br[0] = bi;

    // Ripple of full-subtract cells, LSB first.
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bo = br[DIGIT];
endmodule

// File: rtl/seq_sub.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
module seq_sub
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_sub_if.slave   bus
);
    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(NDIG);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bo;
    logic [WIDTH-1:0] res_asm;
    logic             last;

    sub_digit #(.DIGIT(DIGIT)) u_dig (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .bi (brw_q),
        .d  (dig_d),
        .bo (dig_bo)
    );

    // Result so far with this cycle's slice shifted in from the MSB end;
    // on the final slice this is the complete difference.
    assign res_asm = (res_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
    assign last    = (cnt_q == CW'(NDIG - 1));

    // Next-state, datapath shift and result-load decisions.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_asm;
                brw_d = dig_bo;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    diff_d  = res_asm;
                    bout_d  = dig_bo;
                    zero_d  = (res_asm == '0);
                    state_d = DONE;
                end
            end
            IDLE, DONE: begin
                // Results persist across a new start; only the working
                // registers are reloaded.
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_seq_sub.sv
// Directed and randomized checks of seq_sub at DIGIT = 4, 1 and 16.
module tb_seq_sub;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;

    seq_sub_if #(.WIDTH(16)) if4 ();
    seq_sub_if #(.WIDTH(16)) if1 ();
    seq_sub_if #(.WIDTH(16)) if16 ();

    seq_sub #(.WIDTH(16), .DIGIT(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    seq_sub #(.WIDTH(16), .DIGIT(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_sub #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done on the DIGIT=4 instance; lat = cycles waited.
    task automatic wait_done4(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (if4.done !== 1'b1 && lat < 40) begin
            if (if4.busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    // Issue one operation on the DIGIT=4 instance and check result + latency.
    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic [15:0] ed, input logic eb, input logic ez);
        int lat, bc;
        if4.a = a; if4.b = b; if4.bin = bin; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        wait_done4(lat, bc);
        chk({tag, "_lat"},  32'(lat), 32'd4);
        chk({tag, "_busy"}, 32'(bc), 32'd4);
        chk({tag, "_diff"}, 32'(if4.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(if4.bout), 32'(eb));
        chk({tag, "_zero"}, 32'(if4.zero), 32'(ez));
        tick();
        chk({tag, "_done_pulse"}, 32'(if4.done), 32'd0);
    endtask

    initial begin
        int lat, bc, ndone, c0, l1, l16, n;
        logic [16:0] ref17;
        logic [15:0] ra, rb;
        logic        rbin;
        logic [15:0] d1, d16;
        logic        b1, b16, z1, z16;

        errors = 0; checks = 0; cyc = 0;
        rst_n = 1'b0;
        if4.start = 0;  if4.a = 0;  if4.b = 0;  if4.bin = 0;
        if1.start = 0;  if1.a = 0;  if1.b = 0;  if1.bin = 0;
        if16.start = 0; if16.a = 0; if16.b = 0; if16.bin = 0;
        tick(); tick();

        chk("rst_busy", 32'(if4.busy), 32'd0);
        chk("rst_done", 32'(if4.done), 32'd0);
        chk("rst_diff", 32'(if4.diff), 32'd0);
        chk("rst_bout", 32'(if4.bout), 32'd0);
        chk("rst_zero", 32'(if4.zero), 32'd0);
        rst_n = 1'b1;
        tick();

        op4("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        op4("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        op4("zero",   16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1);

        // Start pulsed mid-run with different operands must be ignored.
        if4.a = 16'h1234; if4.b = 16'h0234; if4.bin = 0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                if4.start = 1'b1; if4.a = 16'hFFFF; if4.b = 16'h0001; if4.bin = 1'b1;
            end else begin
                if4.start = 1'b0;
            end
            tick();
            if (if4.done === 1'b1) ndone++;
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_diff",  32'(if4.diff), 32'h1000);
        chk("ign_bout",  32'(if4.bout), 32'd0);

        // Back-to-back: start held in the DONE cycle.
        if4.a = 16'h0000; if4.b = 16'h0001; if4.bin = 0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        wait_done4(lat, bc);
        chk("b2b_first_lat", 32'(lat), 32'd4);
        c0 = cyc;
        if4.a = 16'hFFFF; if4.b = 16'h8000; if4.bin = 0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        wait_done4(lat, bc);
        chk("b2b_gap",  32'(cyc - c0), 32'd5);
        chk("b2b_diff", 32'(if4.diff), 32'h7FFF);
        chk("b2b_bout", 32'(if4.bout), 32'd0);
        chk("b2b_zero", 32'(if4.zero), 32'd0);
        tick();

        // Reset mid-run after two slices.
        if4.a = 16'h1234; if4.b = 16'h0234; if4.bin = 0; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        tick(); tick();
        chk("mid_busy_pre", 32'(if4.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(if4.busy), 32'd0);
        chk("mid_done", 32'(if4.done), 32'd0);
        chk("mid_diff", 32'(if4.diff), 32'd0);
        chk("mid_bout", 32'(if4.bout), 32'd0);
        chk("mid_zero", 32'(if4.zero), 32'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if4.done === 1'b1 || if4.busy === 1'b1) ndone++;
        end
        chk("mid_quiet", 32'(ndone), 32'd0);
        op4("post_rst", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);

        // DIGIT=1 and DIGIT=16 against an independent 17-bit reference.
        for (int v = 0; v < 1000; v++) begin
            if (v == 0) begin
                ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1;
            end else if (v == 1) begin
                ra = 16'hFFFF; rb = 16'h0000; rbin = 1'b0;
            end else if (v == 2) begin
                ra = 16'h8000; rb = 16'h7FFF; rbin = 1'b1;
            end else begin
                ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            end
            ref17 = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};

            if1.a = ra;  if1.b = rb;  if1.bin = rbin;  if1.start = 1'b1;
            if16.a = ra; if16.b = rb; if16.bin = rbin; if16.start = 1'b1;
            tick();
            if1.start = 1'b0; if16.start = 1'b0;
            l1 = -1; l16 = -1; n = 0;
            d1 = 0; d16 = 0; b1 = 0; b16 = 0; z1 = 0; z16 = 0;
            while ((l1 < 0 || l16 < 0) && n < 40) begin
                tick();
                n++;
                if (if1.done === 1'b1 && l1 < 0) begin
                    l1 = n; d1 = if1.diff; b1 = if1.bout; z1 = if1.zero;
                end
                if (if16.done === 1'b1 && l16 < 0) begin
                    l16 = n; d16 = if16.diff; b16 = if16.bout; z16 = if16.zero;
                end
            end
            chk("d1_lat",   32'(l1), 32'd16);
            chk("d1_diff",  32'(d1), 32'(ref17[15:0]));
            chk("d1_bout",  32'(b1), 32'(ref17[16]));
            chk("d1_zero",  32'(z1), 32'(ref17[15:0] == 16'd0));
            chk("d16_lat",  32'(l16), 32'd1);
            chk("d16_diff", 32'(d16), 32'(ref17[15:0]));
            chk("d16_bout", 32'(b16), 32'(ref17[16]));
            chk("d16_zero", 32'(z16), 32'(ref17[15:0] == 16'd0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_sub.md
Name: seq_sub

Overview:
Multi-cycle, parametrised binary subtractor computing diff = a - b - bin over WIDTH bits, DIGIT bits per clock, LSB slice first.
- Borrow is chained between slices in a flip-flop.
- Gives the datapath a wide subtractor with a start/done handshake, final borrow-out and zero flag, at the area cost of one DIGIT-bit subtract slice.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when not busy.
a  input  WIDTH  minuend, captured on accepted start.
b  input  WIDTH  subtrahend, captured on accepted start.
bin  input  1  borrow-in, captured on accepted start.
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse when result registers update.
diff  output  WIDTH  result a - b - bin mod 2^WIDTH.
bout  output  1  final borrow-out (1 when a < b + bin, unsigned).
zero  output  1  1 when diff == 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, bout, zero, diff = 0; internal shift registers, slice counter and borrow FF = 0.
- Derived constant: NDIG = WIDTH/DIGIT. Counter width is clog2(NDIG), minimum 1.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1 for exactly this cycle.
- Accepted start: start=1 while in IDLE or DONE.
  - Capture a and b into shift registers and bin into the borrow FF; clear the counter; go to RUN.
  - start while in RUN is ignored, with no effect on the operation in flight.
- RUN, each cycle:
  - Slice result {borrow_next, d} = a_sh[DIGIT-1:0] - b_sh[DIGIT-1:0] - borrow.
  - Shift d into the result shift register from the MSB end; shift a_sh and b_sh right by DIGIT; borrow <= borrow_next; counter++.
- When counter == NDIG-1 in RUN: on that edge, load diff, bout=borrow_next and zero=(assembled diff==0), then go to DONE.
- Latency: start accepted at edge T → done high in the cycle after edge T+NDIG. Results visible in the same cycle as done.
- DONE → IDLE next cycle unless start=1, in which case DONE → RUN (back-to-back, one idle cycle between results).
- diff, bout and zero hold their last value until the next completion. They are NOT cleared on start.
- DIGIT == WIDTH: NDIG=1, single RUN cycle. Behaviour is otherwise identical.
- Wrap-around: result is modulo 2^WIDTH; underflow is indicated only by bout.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse, no partial result exposed.
- Inputs a, b and bin may change freely after the accepting edge.

Decomposition:
- Shared package seq_sub_pkg:
  - state enum {IDLE, RUN, DONE} in 2 bits.
  - function/localparam for NDIG and counter width.
- One combinational sub-module, sub_digit (parameter DIGIT): inputs x, y, bi; outputs d, bo.
  - Built as a ripple of full-subtract cells; the LSB cell is equivalent to the existing half-subtractor extended with borrow-in.
- seq_sub instantiates one sub_digit plus the FSM, counter and shift registers.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0234, bin=0 → done in the 4th cycle after the accepting edge; diff=0x1000, bout=0, zero=0; busy high for exactly 4 cycles.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, zero=0. Then a=0x0005, b=0x0004, bin=1 → diff=0x0000, bout=0, zero=1.
- start pulsed again during RUN with different operands → ignored; first result (0x1000) produced, exactly one done pulse.
- start held high in the DONE cycle with a=0xFFFF, b=0x8000 → immediate new RUN; diff=0x7FFF, bout=0, one cycle after the previous done plus 4.
- rst_n low for 1 cycle mid-RUN (after 2 slices) → all outputs 0 asynchronously, state IDLE, no done pulse; a fresh start then completes correctly.
- Re-parametrise DIGIT=1 and DIGIT=16: random 1000-vector comparison against a - b - bin reference; latency 16 and 1 cycles respectively.
